// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL power-up/relock sequencer: state encoding,
// event-counter width and small width/saturation helpers.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RST_PLL   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    ENABLE    = 3'd3,
    RELEASE   = 3'd4,
    RUN       = 3'd5
  } state_e;

  localparam int EVT_CNT_W = 8;

  // Bits needed to hold 0..max_val-1; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val <= 1) ? 1 : $clog2(max_val);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
    return (v == {EVT_CNT_W{1'b1}}) ? v : v + EVT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/sync_ff2.sv
// Generic two-flop synchronizer for single-bit-per-lane asynchronous inputs.
// Both stages reset to 0.
module sync_ff2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: sequential state uses non-blocking assignments so both stages
  // sample their inputs at the same edge and the chain really is two deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_rst_seq.sv
// Power-up/relock sequencer: pulses the PLL reset, qualifies lock, gates the
// PLL output clocks on one by one and finally releases the SoC reset.
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int N_CLK            = 3,
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int LOCK_TIMEOUT_CYC = 50000,
  parameter int EN_GAP_CYC       = 64,
  parameter int SYS_RST_DLY_CYC  = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pll_lock,
  input  logic                 restart_req,
  output logic                 pll_reset,
  output logic [N_CLK-1:0]     pll_enclk,
  output logic                 sys_rst_n,
  output logic                 ready,
  output logic [EVT_CNT_W-1:0] relock_cnt,
  output logic [EVT_CNT_W-1:0] timeout_cnt
);

  if (N_CLK < 1 || RST_PULSE_CYC < 1 || LOCK_STABLE_CYC < 1 ||
      LOCK_TIMEOUT_CYC < 1 || EN_GAP_CYC < 1 || SYS_RST_DLY_CYC < 1) begin : g_param_check
    $error("pll_rst_seq: every parameter must be >= 1");
  end

  localparam int MAX_CYC = max2(max2(max2(RST_PULSE_CYC, LOCK_STABLE_CYC),
                                     max2(LOCK_TIMEOUT_CYC, EN_GAP_CYC)),
                                SYS_RST_DLY_CYC);
  localparam int TMR_W = cnt_width(MAX_CYC);
  localparam int IDX_W = cnt_width(N_CLK);

  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(LOCK_STABLE_CYC - 1);
  localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LAST    = TMR_W'(EN_GAP_CYC - 1);
  localparam logic [TMR_W-1:0] DLY_LAST    = TMR_W'(SYS_RST_DLY_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_CLK - 1);

  logic lock_s;

  sync_ff2 #(.WIDTH(1)) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_e               state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [IDX_W-1:0]     en_idx_q, en_idx_d;
  logic [EVT_CNT_W-1:0] relock_q, relock_d;
  logic [EVT_CNT_W-1:0] timeout_q, timeout_d;
  logic                 pll_reset_q, pll_reset_d;
  logic [N_CLK-1:0]     enclk_q, enclk_d;
  logic                 sys_rst_n_q, sys_rst_n_d;
  logic                 ready_q, ready_d;
  logic                 clocks_on;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TMR_W'(1);
    en_idx_d  = en_idx_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;
    clocks_on = (state_q == ENABLE) || (state_q == RELEASE) || (state_q == RUN);

    // Lock loss while clocks are gated on outranks a coincident restart so it
    // is still counted; restart is ignored during the reset pulse.
    if (clocks_on && !lock_s) begin
      state_d  = RST_PLL;
      relock_d = sat_inc(relock_q);
    end else if (restart_req && state_q != RST_PLL) begin
      state_d = RST_PLL;
    end else begin
      unique case (state_q)
        RST_PLL: begin
          if (timer_q == RST_LAST) state_d = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state_d = STABLE;
          end else if (timer_q == TO_LAST) begin
            state_d   = RST_PLL;
            timeout_d = sat_inc(timeout_q);
          end
        end
        STABLE: begin
          if (!lock_s)                     state_d = WAIT_LOCK;
          else if (timer_q == STABLE_LAST) state_d = ENABLE;
        end
        ENABLE: begin
          if (timer_q == GAP_LAST) begin
            timer_d = '0;
            if (en_idx_q == IDX_LAST) state_d = RELEASE;
            else                      en_idx_d = en_idx_q + IDX_W'(1);
          end
        end
        RELEASE: begin
          if (timer_q == DLY_LAST) state_d = RUN;
        end
        RUN: begin
          timer_d = '0;
        end
        default: state_d = RST_PLL;
      endcase
    end

    if (state_d != state_q) begin
      timer_d  = '0;
      en_idx_d = '0;
    end

    // Outputs are decoded from the next state and registered with it, so they
    // only move on transitions and come straight from flops.
    pll_reset_d = (state_d == RST_PLL);
    sys_rst_n_d = (state_d == RUN);
    ready_d     = (state_d == RUN);
    enclk_d     = '0;
    for (int i = 0; i < N_CLK; i++) begin
      if (state_d == ENABLE)                         enclk_d[i] = (i <= int'(en_idx_d));
      else if (state_d == RELEASE || state_d == RUN) enclk_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_PLL;
      timer_q     <= '0;
      en_idx_q    <= '0;
      relock_q    <= '0;
      timeout_q   <= '0;
      pll_reset_q <= 1'b1;
      enclk_q     <= '0;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      en_idx_q    <= en_idx_d;
      relock_q    <= relock_d;
      timeout_q   <= timeout_d;
      pll_reset_q <= pll_reset_d;
      enclk_q     <= enclk_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_enclk   = enclk_q;
  assign sys_rst_n   = sys_rst_n_q;
  assign ready       = ready_q;
  assign relock_cnt  = relock_q;
  assign timeout_cnt = timeout_q;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Directed bench for pll_rst_seq with short sim parameters; expected output
// words {pll_reset, enclk[2:0], sys_rst_n, ready} are hand-derived per cycle.
module tb_pll_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       restart_req;
  logic       pll_reset;
  logic [2:0] pll_enclk;
  logic       sys_rst_n;
  logic       ready;
  logic [7:0] relock_cnt;
  logic [7:0] timeout_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_rst_seq #(
    .N_CLK            (3),
    .RST_PULSE_CYC    (4),
    .LOCK_STABLE_CYC  (8),
    .LOCK_TIMEOUT_CYC (40),
    .EN_GAP_CYC       (4),
    .SYS_RST_DLY_CYC  (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .restart_req (restart_req),
    .pll_reset   (pll_reset),
    .pll_enclk   (pll_enclk),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .relock_cnt  (relock_cnt),
    .timeout_cnt (timeout_cnt)
  );

  localparam logic [5:0] O_RST = 6'b1_000_00;
  localparam logic [5:0] O_IDL = 6'b0_000_00;
  localparam logic [5:0] O_E1  = 6'b0_001_00;
  localparam logic [5:0] O_E2  = 6'b0_011_00;
  localparam logic [5:0] O_E3  = 6'b0_111_00;
  localparam logic [5:0] O_RUN = 6'b0_111_11;

  function automatic logic [5:0] obs();
    return {pll_reset, pll_enclk, sys_rst_n, ready};
  endfunction

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 unit after edge e0, with reset just released.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    pll_lock = 1'b0;
    restart_req = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_lock = 1'b0;
    restart_req = 1'b0;
    step(2);
    checks++; if (obs() !== O_RST) begin errors++; $display("FAIL reset_outputs: got %b exp %b", obs(), O_RST); end
    checks++; if (relock_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin errors++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", relock_cnt, timeout_cnt); end
    rst_n = 1'b1;
  endtask

  // Lock held low: 4-cycle pulse then 40-cycle wait, repeating every 44.
  task automatic test_timeout();
    step(3);
    checks++; if (obs() !== O_RST) begin errors++; $display("FAIL to_pulse_len: got %b exp %b", obs(), O_RST); end
    step(1);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL to_pulse_end: got %b exp %b", obs(), O_IDL); end
    step(39);
    checks++; if (obs() !== O_IDL || timeout_cnt !== 8'd0) begin errors++; $display("FAIL to_wait1: got %b/%0d exp %b/0", obs(), timeout_cnt, O_IDL); end
    step(1);
    checks++; if (obs() !== O_RST || timeout_cnt !== 8'd1) begin errors++; $display("FAIL to_first: got %b/%0d exp %b/1", obs(), timeout_cnt, O_RST); end
    step(44);
    checks++; if (obs() !== O_RST || timeout_cnt !== 8'd2) begin errors++; $display("FAIL to_second: got %b/%0d exp %b/2", obs(), timeout_cnt, O_RST); end
    step(43);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL to_wait3: got %b exp %b", obs(), O_IDL); end
    step(1);
    checks++; if (obs() !== O_RST || timeout_cnt !== 8'd3) begin errors++; $display("FAIL to_third: got %b/%0d exp %b/3", obs(), timeout_cnt, O_RST); end
    // Restart during the pulse must not stretch it.
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    step(2);
    checks++; if (obs() !== O_RST) begin errors++; $display("FAIL restart_in_rst_hold: got %b exp %b", obs(), O_RST); end
    step(1);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL restart_in_rst_end: got %b exp %b", obs(), O_IDL); end
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    checks++; if (obs() !== O_RST || timeout_cnt !== 8'd3) begin errors++; $display("FAIL restart_in_wait: got %b/%0d exp %b/3", obs(), timeout_cnt, O_RST); end
  endtask

  // Lock driven 10 cycles after pll_reset falls; ENABLE at e25, RUN at e43.
  task automatic test_lock_seq();
    apply_reset();
    step(4);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL seq_pulse_end: got %b exp %b", obs(), O_IDL); end
    step(10);
    pll_lock = 1'b1;
    step(10);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL seq_stable: got %b exp %b", obs(), O_IDL); end
    step(1);
    checks++; if (obs() !== O_E1) begin errors++; $display("FAIL seq_en0: got %b exp %b", obs(), O_E1); end
    step(3);
    checks++; if (obs() !== O_E1) begin errors++; $display("FAIL seq_en0_hold: got %b exp %b", obs(), O_E1); end
    step(1);
    checks++; if (obs() !== O_E2) begin errors++; $display("FAIL seq_en1: got %b exp %b", obs(), O_E2); end
    step(4);
    checks++; if (obs() !== O_E3) begin errors++; $display("FAIL seq_en2: got %b exp %b", obs(), O_E3); end
    step(9);
    checks++; if (obs() !== O_E3) begin errors++; $display("FAIL seq_release: got %b exp %b", obs(), O_E3); end
    step(1);
    checks++; if (obs() !== O_RUN) begin errors++; $display("FAIL seq_run: got %b exp %b", obs(), O_RUN); end
    checks++; if (relock_cnt !== 8'd0 || timeout_cnt !== 8'd0) begin errors++; $display("FAIL seq_counts: got %0d/%0d exp 0/0", relock_cnt, timeout_cnt); end
  endtask

  // From RUN at e43: lock falls, outputs drop 3 edges later, then re-sequence.
  task automatic test_lock_loss_run();
    pll_lock = 1'b0;
    step(2);
    checks++; if (obs() !== O_RUN) begin errors++; $display("FAIL loss_sync_delay: got %b exp %b", obs(), O_RUN); end
    step(1);
    checks++; if (obs() !== O_RST || relock_cnt !== 8'd1) begin errors++; $display("FAIL loss_drop: got %b/%0d exp %b/1", obs(), relock_cnt, O_RST); end
    pll_lock = 1'b1;
    step(12);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL loss_restable: got %b exp %b", obs(), O_IDL); end
    step(1);
    checks++; if (obs() !== O_E1) begin errors++; $display("FAIL loss_reenable: got %b exp %b", obs(), O_E1); end
    step(18);
    checks++; if (obs() !== O_RUN || relock_cnt !== 8'd1) begin errors++; $display("FAIL loss_rerun: got %b/%0d exp %b/1", obs(), relock_cnt, O_RUN); end
  endtask

  // Restart alone in RUN (e77), then restart coinciding with lock loss in RELEASE.
  task automatic test_restart_release();
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    checks++; if (obs() !== O_RST || relock_cnt !== 8'd1 || timeout_cnt !== 8'd0) begin errors++; $display("FAIL restart_run: got %b/%0d/%0d exp %b/1/0", obs(), relock_cnt, timeout_cnt, O_RST); end
    step(24);
    checks++; if (obs() !== O_E3) begin errors++; $display("FAIL restart_en2: got %b exp %b", obs(), O_E3); end
    step(2);
    pll_lock = 1'b0;
    step(2);
    checks++; if (obs() !== O_E3) begin errors++; $display("FAIL both_pre: got %b exp %b", obs(), O_E3); end
    restart_req = 1'b1;
    step(1);
    restart_req = 1'b0;
    checks++; if (obs() !== O_RST || relock_cnt !== 8'd2) begin errors++; $display("FAIL both_counted: got %b/%0d exp %b/2", obs(), relock_cnt, O_RST); end
  endtask

  // One-cycle lock glitch in STABLE: ENABLE moves from e120 to e126.
  task automatic test_stable_glitch();
    pll_lock = 1'b1;
    step(7);
    pll_lock = 1'b0;
    step(1);
    pll_lock = 1'b1;
    step(10);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL glitch_restart: got %b exp %b", obs(), O_IDL); end
    step(1);
    checks++; if (obs() !== O_E1) begin errors++; $display("FAIL glitch_enable: got %b exp %b", obs(), O_E1); end
    checks++; if (relock_cnt !== 8'd2 || timeout_cnt !== 8'd0) begin errors++; $display("FAIL glitch_counts: got %0d/%0d exp 2/0", relock_cnt, timeout_cnt); end
  endtask

  task automatic test_async_reset_enable();
    step(5);
    checks++; if (obs() !== O_E2) begin errors++; $display("FAIL arst_pre: got %b exp %b", obs(), O_E2); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (obs() !== O_RST || relock_cnt !== 8'd0) begin errors++; $display("FAIL arst_immediate: got %b/%0d exp %b/0", obs(), relock_cnt, O_RST); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    checks++; if (obs() !== O_RST) begin errors++; $display("FAIL arst_pulse: got %b exp %b", obs(), O_RST); end
    step(1);
    checks++; if (obs() !== O_IDL) begin errors++; $display("FAIL arst_wait: got %b exp %b", obs(), O_IDL); end
    step(9);
    checks++; if (obs() !== O_E1) begin errors++; $display("FAIL arst_reenable: got %b exp %b", obs(), O_E1); end
  endtask

  // 260 timeout periods of 44 cycles must leave the counter pinned at 255.
  task automatic test_saturation();
    apply_reset();
    step(44 * 260 + 5);
    checks++; if (timeout_cnt !== 8'hFF || relock_cnt !== 8'd0) begin errors++; $display("FAIL saturate: got %0d/%0d exp 255/0", timeout_cnt, relock_cnt); end
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_lock_seq();
    test_lock_loss_run();
    test_restart_release();
    test_stable_glitch();
    test_async_reset_enable();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
